// File: rtl/hb_pkg.sv
// Shared halfband constants: Q15 coefficients (gain-2 scaled), datapath widths and FSM encodings.
// Used by the x2 interpolator and the hb1 decimator.
package hb_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 36;

    // C1 + C3 + C5 = 16384, which with the factor-2 interpolation gain gives unity DC gain
    localparam logic signed [COEF_W-1:0] C1 = 16'sd19200;
    localparam logic signed [COEF_W-1:0] C3 = -16'sd3200;
    localparam logic signed [COEF_W-1:0] C5 = 16'sd384;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MAC1   = 3'd1;
    localparam logic [2:0] ST_MAC3   = 3'd2;
    localparam logic [2:0] ST_MAC5   = 3'd3;
    localparam logic [2:0] ST_EMIT_O = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_EMIT_E = 3'd6;

endpackage

// File: rtl/hb_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC and saturation from IN_W to OUT_W bits.
module hb_round_sat
    import hb_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = DATA_W,
    parameter int FRAC  = 15
) (
    input  logic signed [IN_W-1:0]  acc_in,
    output logic signed [OUT_W-1:0] y_out
);

    localparam logic signed [IN_W-1:0] HALF  = {{(IN_W-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] biased;
    logic signed [IN_W-1:0] shifted;

    always_comb begin
        biased  = acc_in + HALF;
        shifted = biased >>> FRAC;
        if (shifted > MAX_V) begin
            y_out = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            y_out = MIN_V[OUT_W-1:0];
        end else begin
            y_out = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/hb_interp.sv
// Halfband x2 interpolator: even phase is the centre-tap delay, odd phase a 3-coefficient
// symmetric sum computed on one shared multiplier over three cycles.
module hb_interp #(
    parameter int OUT_SPACING_CLKS = 12,
    parameter int DATA_W           = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     x_in_valid,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_out_valid,
    output logic                     overrun
);

    import hb_pkg::*;

    localparam int PAIR_W = DATA_W + 1;
    localparam int PROD_W = PAIR_W + COEF_W;
    localparam int CNT_W  = (OUT_SPACING_CLKS > 1) ? $clog2(OUT_SPACING_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OUT_SPACING_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] d [0:5];
    logic signed [ACC_W-1:0]  acc;

    logic signed [PAIR_W-1:0] pair;
    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] rs_out;

    // Shared multiplier: pick the symmetric tap pair and coefficient for the current MAC step
    always_comb begin
        pair = '0;
        coef = '0;
        case (state)
            ST_MAC1: begin
                pair = PAIR_W'(d[2]) + PAIR_W'(d[3]);
                coef = C1;
            end
            ST_MAC3: begin
                pair = PAIR_W'(d[1]) + PAIR_W'(d[4]);
                coef = C3;
            end
            ST_MAC5: begin
                pair = PAIR_W'(d[0]) + PAIR_W'(d[5]);
                coef = C5;
            end
            default: begin
                pair = '0;
                coef = '0;
            end
        endcase
        prod = PROD_W'(pair) * PROD_W'(coef);
    end

    hb_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .FRAC  (15)
    ) u_round_sat (
        .acc_in (acc),
        .y_out  (rs_out)
    );

    // Samples arriving outside IDLE are dropped so the delay line never shifts mid-computation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            y_out       <= '0;
            y_out_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                d[i] <= '0;
            end
        end else begin
            y_out_valid <= 1'b0;
            if (x_in_valid && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (x_in_valid) begin
                        for (int i = 5; i > 0; i--) begin
                            d[i] <= d[i-1];
                        end
                        d[0]  <= x_in;
                        acc   <= '0;
                        state <= ST_MAC1;
                    end
                end
                ST_MAC1: begin
                    acc   <= acc + ACC_W'(prod);
                    state <= ST_MAC3;
                end
                ST_MAC3: begin
                    acc   <= acc + ACC_W'(prod);
                    state <= ST_MAC5;
                end
                ST_MAC5: begin
                    acc   <= acc + ACC_W'(prod);
                    state <= ST_EMIT_O;
                end
                ST_EMIT_O: begin
                    y_out       <= rs_out;
                    y_out_valid <= 1'b1;
                    cnt         <= CNT_LOAD;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) begin
                        state <= ST_EMIT_E;
                    end
                end
                ST_EMIT_E: begin
                    y_out       <= d[2];
                    y_out_valid <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hb_interp.md
Name: hb_interp

Overview:
- Halfband x2 interpolation filter for the playback path: 16-bit signed samples at 64 kHz in, 128 kHz out; the mirror of the hb1 decimator on the capture path.
- Runs on the 1.536 MHz system clock; input samples arrive as single-cycle valid strobes.
- 11-tap halfband implemented as two polyphase branches:
  - even branch is a pure delay (centre tap);
  - odd branch is a 3-coefficient symmetric sum computed on one shared multiplier over 3 cycles.

Parameters:
- OUT_SPACING_CLKS, 12, clocks between the two output strobes produced per input (1.536 MHz / 128 kHz).
- DATA_W, 16, input/output sample width.

Ports:
- clk  input  1  system clock, 1.536 MHz
- reset_n  input  1  asynchronous, active-low reset
- x_in  input  DATA_W  signed input sample
- x_in_valid  input  1  one-cycle strobe; x_in sampled on this edge
- y_out  output  DATA_W  signed output sample, held between strobes
- y_out_valid  output  1  one-cycle strobe per output sample
- overrun  output  1  sticky; set when an input arrives while busy

Behaviour:
- Reset (asynchronous, active-low):
  - y_out=0, y_out_valid=0, overrun=0;
  - delay line d0..d5 cleared to 0;
  - accumulator=0, FSM=IDLE, spacing counter=0;
  - reset asserted mid-operation aborts immediately; no pending output is emitted after release.
- Coefficients, Q15, pre-scaled by interpolation gain 2: C1=19200, C3=-3200, C5=384 (C1+C3+C5=16384, so DC gain is exactly 1).
- Odd output: yo = C1*(d2+d3) + C3*(d1+d4) + C5*(d0+d5).
- Even output: ye = d2.
- Width rules:
  - pair sums are 17-bit signed;
  - products are 33-bit;
  - accumulator is 36-bit signed.
- Round and saturate: add 2^14, arithmetic shift right by 15, saturate to [-32768, 32767].
- FSM states:
  - IDLE: when x_in_valid, shift d5<=d4 … d1<=d0, d0<=x_in; clear accumulator; go to MAC1.
  - MAC1, MAC3, MAC5 (one cycle each): accumulate the C1, C3 and C5 terms in that order.
  - EMIT_O: register y_out=round_sat(acc), pulse y_out_valid; load spacing counter with OUT_SPACING_CLKS-1.
  - WAIT: decrement the counter; at 0 go to EMIT_E.
  - EMIT_E: y_out=d2, pulse y_out_valid; return to IDLE.
- Timing:
  - input accepted on edge t0;
  - odd strobe registered on edge t0+4;
  - even strobe registered on edge t0+4+OUT_SPACING_CLKS;
  - IDLE is re-entered on the following edge.
- Busy window is 5+OUT_SPACING_CLKS = 17 clocks, which is under the 24-clock input period.
- Output order per input: interp(d3,d2), then d2. This is a continuous, correctly interleaved 128 kHz stream with group delay of 2.5 input samples.
- Overrun: x_in_valid in any state other than IDLE drops the sample (delay line untouched), sets overrun, and does not disturb the FSM. An input arriving on the same edge that EMIT_E returns to IDLE is also dropped.
- x_in_valid held high continuously: accepted only once per IDLE visit; every other cycle counts as overrun.
- y_out_valid is never high for two consecutive cycles.

Decomposition:
- hb_pkg:
  - C1/C3/C5 Q15 constants;
  - ACC_W=36, COEF_W=16, DATA_W;
  - FSM state enum;
  - shared with hb1.
- Sub-module hb_round_sat: combinational round-half-up, shift by 15 and saturate from ACC_W to DATA_W. Reused later by hb1 and the volume stage.

Test Plan:
- DC 1000 for 20 inputs at a 24-clock period → after 6 inputs, every output is exactly 1000. Output count equals 2x input count; strobes are 12 clocks apart.
- Impulse 10000 then zeros → output stream 117, 0, -977, 0, 5859, 10000, 5859, 0, -977, 0, 117, 0, then all 0.
- Inputs 32767, -32768, 32767, 32767, -32768, 32767 → sixth input yields odd output 32767 (saturated, no wrap) and even output 32767.
- Latency check: x_in_valid on edge t0 → y_out_valid high after edges t0+4 and t0+16 only; overrun stays 0.
- Second x_in_valid 8 clocks after the first → sample dropped, overrun=1 and stays 1, both outputs of the first sample unchanged.
- Assert reset_n low during WAIT → y_out=0, y_out_valid=0 immediately. After release, no stray strobe; a following impulse reproduces the impulse sequence from scratch.
